// File: rtl/zone_rate_controller_if.sv
// Bus bundle for the zone rate controller: head position input, table
// programming port and the rate req/ack handshake toward the data separator.
//   master : the controller side (drives zone, rate_word, rate_req,
//            zone_changed, busy; samples everything else)
//   slave  : host / DPLL side (drives enable, current_track, cfg_*, rate_ack)
interface zone_rate_controller_if #(
  parameter int unsigned NUM_ZONES = 5,
  parameter int unsigned TRACK_W   = 8,
  parameter int unsigned RATE_W    = 16
);
  localparam int unsigned ZW = (NUM_ZONES > 1) ? $clog2(NUM_ZONES) : 1;

  logic               enable;
  logic [TRACK_W-1:0] current_track;
  logic               cfg_we;
  logic               cfg_sel;
  logic [ZW-1:0]      cfg_addr;
  logic [RATE_W-1:0]  cfg_data;
  logic [ZW-1:0]      zone;
  logic [RATE_W-1:0]  rate_word;
  logic               rate_req;
  logic               rate_ack;
  logic               zone_changed;
  logic               busy;

  modport master (
    input  enable, current_track, cfg_we, cfg_sel, cfg_addr, cfg_data, rate_ack,
    output zone, rate_word, rate_req, zone_changed, busy
  );

  modport slave (
    output enable, current_track, cfg_we, cfg_sel, cfg_addr, cfg_data, rate_ack,
    input  zone, rate_word, rate_req, zone_changed, busy
  );
endinterface

// File: rtl/zone_rate_controller.sv
// Programmable track-to-zone mapper for a zoned-CAV/CLV data separator.
// Maps the head track to a zone through a loadable boundary table, keeps a
// per-zone DPLL rate word, debounces seeks and commits zone changes to the
// DPLL over a req/ack handshake.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   bus (master)       enable, current_track, cfg_we/sel/addr/data in;
//                      zone, rate_word, rate_req, zone_changed, busy out;
//                      rate_ack in
module zone_rate_controller #(
  parameter int unsigned NUM_ZONES     = 5,
  parameter int unsigned TRACK_W       = 8,
  parameter int unsigned RATE_W        = 16,
  parameter int unsigned ZONE_TRACKS   = 16,
  parameter int unsigned SETTLE_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  zone_rate_controller_if.master bus
);
  localparam int unsigned ZW = (NUM_ZONES > 1) ? $clog2(NUM_ZONES) : 1;
  localparam int unsigned CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, SETTLE, REQ} state_t;

  state_t             state_q, state_d;
  logic [TRACK_W-1:0] boundary_q [NUM_ZONES];
  logic [TRACK_W-1:0] boundary_d [NUM_ZONES];
  logic [RATE_W-1:0]  rate_q     [NUM_ZONES];
  logic [RATE_W-1:0]  rate_d     [NUM_ZONES];
  logic [TRACK_W-1:0] last_track_q, last_track_d;
  logic               eval_pending_q, eval_pending_d;
  logic [ZW-1:0]      idx_q, idx_d;
  logic [ZW-1:0]      acc_q, acc_d;
  logic [ZW-1:0]      cand_q, cand_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [ZW-1:0]      zone_q, zone_d;
  logic [RATE_W-1:0]  rate_word_q, rate_word_d;
  logic               rate_req_q, rate_req_d;
  logic               zone_changed_q, zone_changed_d;
  logic               busy_q, busy_d;
  logic               cfg_accept;
  logic               restart;
  logic               track_moved;
  logic               scan_last;
  logic               settle_done;
  logic               hit;
  logic [ZW-1:0]      acc_next;

  assign track_moved = (bus.current_track != last_track_q);
  assign scan_last   = (idx_q == ZW'(NUM_ZONES - 1));
  assign settle_done = (cnt_q == CW'(SETTLE_CYCLES - 1));
  assign hit         = (last_track_q >= boundary_q[idx_q]);
  assign acc_next    = acc_q + ZW'(hit);

  assign bus.zone         = zone_q;
  assign bus.rate_word    = rate_word_q;
  assign bus.rate_req     = rate_req_q;
  assign bus.zone_changed = zone_changed_q;
  assign bus.busy         = busy_q;

  // Table write port; out-of-range indices and boundary[0] are dropped.
  always_comb begin
    boundary_d = boundary_q;
    rate_d     = rate_q;
    cfg_accept = 1'b0;
    for (int i = 0; i < int'(NUM_ZONES); i++) begin
      if (bus.cfg_we && (bus.cfg_addr == ZW'(i))) begin
        if (bus.cfg_sel) begin
          rate_d[i]  = bus.cfg_data;
          cfg_accept = 1'b1;
        end else if (i != 0) begin
          boundary_d[i] = TRACK_W'(bus.cfg_data);
          cfg_accept    = 1'b1;
        end
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; disable overrides every state, including a live request.
  always_comb begin
    state_d = state_q;
    if (!bus.enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (track_moved || eval_pending_q) state_d = SCAN;
        SCAN:    if (!track_moved && scan_last) state_d = SETTLE;
        SETTLE: begin
          if (track_moved)      state_d = SCAN;
          else if (settle_done) state_d = (cand_q != zone_q) ? REQ : IDLE;
        end
        REQ:     if (bus.rate_ack) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath and output next values.
  always_comb begin
    last_track_d   = last_track_q;
    eval_pending_d = eval_pending_q;
    idx_d          = idx_q;
    acc_d          = acc_q;
    cand_d         = cand_q;
    cnt_d          = cnt_q;
    zone_d         = zone_q;
    zone_changed_d = 1'b0;
    restart        = 1'b0;
    if (!bus.enable) begin
      zone_d         = '0;
      eval_pending_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (track_moved || eval_pending_q) begin
            restart        = 1'b1;
            eval_pending_d = 1'b0;
          end
        end
        SCAN: begin
          if (track_moved) begin
            restart = 1'b1;
          end else begin
            acc_d = acc_next;
            if (scan_last) begin
              cand_d = acc_next;
              cnt_d  = '0;
            end else begin
              idx_d = idx_q + ZW'(1);
            end
          end
        end
        SETTLE: begin
          if (track_moved) restart = 1'b1;
          else             cnt_d   = cnt_q + CW'(1);
        end
        REQ: begin
          // The request is never withdrawn; remember to re-evaluate instead.
          if (track_moved) eval_pending_d = 1'b1;
          if (bus.rate_ack) begin
            zone_d         = cand_q;
            zone_changed_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
    if (restart) begin
      idx_d        = ZW'(1);
      acc_d        = '0;
      last_track_d = bus.current_track;
    end
    if (cfg_accept) eval_pending_d = 1'b1;
    rate_req_d = (state_d == REQ);
    busy_d     = (state_d != IDLE);
    // Proposed word frozen for the whole request; otherwise track the committed zone.
    if ((state_q == REQ) && (state_d == REQ)) rate_word_d = rate_word_q;
    else if (state_d == REQ)                  rate_word_d = rate_d[cand_q];
    else                                      rate_word_d = rate_d[zone_d];
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_ZONES); i++) begin
        boundary_q[i] <= TRACK_W'(i * ZONE_TRACKS);
        rate_q[i]     <= '0;
      end
      last_track_q   <= bus.current_track;
      eval_pending_q <= 1'b1;
      idx_q          <= ZW'(1);
      acc_q          <= '0;
      cand_q         <= '0;
      cnt_q          <= '0;
      zone_q         <= '0;
      rate_word_q    <= '0;
      rate_req_q     <= 1'b0;
      zone_changed_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      boundary_q     <= boundary_d;
      rate_q         <= rate_d;
      last_track_q   <= last_track_d;
      eval_pending_q <= eval_pending_d;
      idx_q          <= idx_d;
      acc_q          <= acc_d;
      cand_q         <= cand_d;
      cnt_q          <= cnt_d;
      zone_q         <= zone_d;
      rate_word_q    <= rate_word_d;
      rate_req_q     <= rate_req_d;
      zone_changed_q <= zone_changed_d;
      busy_q         <= busy_d;
    end
  end
endmodule
